// File: rtl/serdes_pkg.sv
// Shared types for the serializer/deserializer pair: beat order and shifter state.
package serdes_pkg;

  typedef enum logic {
    DIR_IDX0_FIRST = 1'b0,
    DIR_IDXN_FIRST = 1'b1
  } dir_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/serializer_if.sv
// Parallel-in / serial-out bundle between a word producer and the serializer.
interface serializer_if
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARL_WIDTH = 8
);

  dir_e                  dir;
  logic                  par_vld;
  logic                  par_rdy;
  logic [DATA_WIDTH-1:0] par [PARL_WIDTH];
  logic [DATA_WIDTH-1:0] ser;
  logic                  ser_en;
  logic                  sof;
  logic                  eof;

  modport master (
    output dir, par_vld, par,
    input  par_rdy, ser, ser_en, sof, eof
  );

  modport slave (
    input  dir, par_vld, par,
    output par_rdy, ser, ser_en, sof, eof
  );

endinterface

// File: rtl/serializer_hold.sv
// One-entry skid buffer holding a word and its beat order while the shifter is busy.
module serializer_hold
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_word [PARL_WIDTH],
  input  dir_e                  wr_dir,
  input  logic                  rd_en,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] rd_word [PARL_WIDTH],
  output dir_e                  rd_dir
);

  always_ff @(posedge clk) begin
    if (rst)        full <= 1'b0;
    else if (wr_en) full <= 1'b1;
    else if (rd_en) full <= 1'b0;
  end

  // NOTE: payload storage is not reset; the full flag alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rd_word <= wr_word;
      rd_dir  <= wr_dir;
    end
  end

endmodule

// File: rtl/serializer.sv
// Word-to-beat serializer: shifter plus one-entry hold buffer, streaming without bubbles.
module serializer
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARL_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serializer_if.slave  bus
);

  localparam int            CW        = (PARL_WIDTH > 1) ? $clog2(PARL_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(PARL_WIDTH - 1);

  typedef logic [DATA_WIDTH-1:0] beat_t;

  ser_state_e    state_q, state_d;
  beat_t         par_in    [PARL_WIDTH];
  beat_t         hold_word [PARL_WIDTH];
  beat_t         ld_word   [PARL_WIDTH];
  beat_t         ld_beats  [PARL_WIDTH];
  beat_t         sh_q      [PARL_WIDTH];
  dir_e          hold_dir, ld_dir;
  logic          hold_full, accept, last_beat;
  logic          load_direct, load_hold, load, hold_wr;
  logic [CW-1:0] cnt_q, cnt_nxt;
  beat_t         ser_q;
  logic          ser_en_q, sof_q, eof_q;

  assign par_in      = bus.par;
  assign bus.par_rdy = ~hold_full;
  assign accept      = bus.par_vld & ~hold_full & ~rst;
  assign last_beat   = (state_q == ST_SHIFT) && (cnt_q == LAST_BEAT);
  assign cnt_nxt     = cnt_q + 1'b1;

  serializer_hold #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARL_WIDTH (PARL_WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hold_wr),
    .wr_word (par_in),
    .wr_dir  (bus.dir),
    .rd_en   (load_hold),
    .full    (hold_full),
    .rd_word (hold_word),
    .rd_dir  (hold_dir)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (last_beat && !hold_full && !accept) state_d = ST_IDLE;
    endcase
  end

  // Load source priority at the word boundary: held word first, then a fresh accept.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch can be inferred.
    load_hold   = last_beat & hold_full;
    load_direct = accept & ((state_q == ST_IDLE) | (last_beat & ~hold_full));
    load        = load_hold | load_direct;
    hold_wr     = accept & ~load_direct;
    ld_dir      = load_hold ? hold_dir : bus.dir;
    for (int i = 0; i < PARL_WIDTH; i++)
      ld_word[i] = load_hold ? hold_word[i] : par_in[i];
    for (int i = 0; i < PARL_WIDTH; i++)
      ld_beats[i] = (ld_dir == DIR_IDX0_FIRST) ? ld_word[i] : ld_word[PARL_WIDTH-1-i];
  end

  // Shifter holds beats in send order; ser shows beat cnt_q of the current word.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      ser_q    <= '0;
      ser_en_q <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      for (int i = 0; i < PARL_WIDTH; i++) sh_q[i] <= '0;
    end else if (load) begin
      sh_q     <= ld_beats;
      cnt_q    <= '0;
      ser_q    <= ld_beats[0];
      ser_en_q <= 1'b1;
      sof_q    <= 1'b1;
      eof_q    <= 1'b0;
    end else if (state_q == ST_SHIFT && !last_beat) begin
      cnt_q <= cnt_nxt;
      ser_q <= sh_q[cnt_nxt];
      sof_q <= 1'b0;
      eof_q <= (cnt_nxt == LAST_BEAT);
    end else begin
      cnt_q    <= '0;
      ser_q    <= '0;
      ser_en_q <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
    end
  end

  assign bus.ser    = ser_q;
  assign bus.ser_en = ser_en_q;
  assign bus.sof    = sof_q;
  assign bus.eof    = eof_q;

endmodule

// File: tb/tb_serializer.sv
// Serializer bench: directed literal cases, then random traffic against a queue model and a deserializer model.
module tb_serializer;
  import serdes_pkg::*;

  localparam int DW = 8;
  localparam int PW = 4;

  logic clk;
  logic rst;

  serializer_if #(.DATA_WIDTH(DW), .PARL_WIDTH(PW)) bus ();

  serializer #(.DATA_WIDTH(DW), .PARL_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: accepted words become a queue of pending beats; one beat leaves per cycle.
  typedef struct packed { logic [DW-1:0] d; logic sof; logic eof; } mbeat_t;
  typedef struct packed { logic d; logic [PW*DW-1:0] w; } sent_t;

  mbeat_t          mq[$];
  sent_t           sent[$];
  logic            m_en, m_sof, m_eof;
  logic [DW-1:0]   m_ser;
  bit              m_valid = 1'b0;
  logic [DW-1:0]   rx_buf [PW];
  int              rx_cnt = 0;
  int              frames = 0;

  always @(posedge clk) begin
    sent_t  s;
    mbeat_t b;
    int     idx;
    m_valid = 1'b1;
    if (rst) begin
      mq.delete();
      sent.delete();
      rx_cnt = 0;
    end else if (bus.par_vld && mq.size() < PW) begin
      s.d = bus.dir;
      for (int i = 0; i < PW; i++) s.w[i*DW +: DW] = bus.par[i];
      sent.push_back(s);
      for (int k = 0; k < PW; k++) begin
        idx   = (bus.dir == DIR_IDXN_FIRST) ? PW - 1 - k : k;
        b.d   = bus.par[idx];
        b.sof = (k == 0);
        b.eof = (k == PW - 1);
        mq.push_back(b);
      end
    end
    if (!rst && mq.size() > 0) begin
      b     = mq.pop_front();
      m_en  = 1'b1;
      m_ser = b.d;
      m_sof = b.sof;
      m_eof = b.eof;
    end else begin
      m_en  = 1'b0;
      m_ser = '0;
      m_sof = 1'b0;
      m_eof = 1'b0;
    end
  end

  // Compare process plus a deserializer that rebuilds each frame index-for-index.
  always @(negedge clk) begin
    sent_t           s;
    logic [PW*DW-1:0] got;
    int              idx;
    if (m_valid) begin
      check("stream", 32'({bus.ser_en, bus.sof, bus.eof, bus.ser}),
                      32'({m_en, m_sof, m_eof, m_ser}));
      check("par_rdy", 32'(bus.par_rdy), 32'(mq.size() < PW));
      if (bus.ser_en === 1'b1) begin
        if (bus.sof) rx_cnt = 0;
        if (rx_cnt < PW) rx_buf[rx_cnt] = bus.ser;
        rx_cnt++;
        if (bus.eof) begin
          check("frame_len", 32'(rx_cnt), 32'(PW));
          check("frame_pending", 32'(sent.size() > 0), 32'd1);
          if (sent.size() > 0) begin
            s   = sent.pop_front();
            got = '0;
            for (int k = 0; k < PW; k++) begin
              idx = s.d ? PW - 1 - k : k;
              got[idx*DW +: DW] = rx_buf[k];
            end
            check("frame_data", 32'(got), 32'(s.w));
            frames++;
          end
        end
      end
    end
  end

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic [31:0] w);
    bus.par_vld = 1'b1;
    bus.dir     = dir_e'(d);
    for (int i = 0; i < PW; i++) bus.par[i] = w[i*DW +: DW];
  endtask

  task automatic exp_cyc(input string name, input logic [7:0] s, input logic en,
                         input logic sof, input logic eof, input logic rdy);
    @(negedge clk);
    check(name, 32'({bus.ser_en, bus.sof, bus.eof, bus.par_rdy, bus.ser}),
                32'({en, sof, eof, rdy, s}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst         = 1'b1;
    bus.par_vld = 1'b0;
    bus.dir     = DIR_IDX0_FIRST;
    for (int i = 0; i < PW; i++) bus.par[i] = '0;
    repeat (3) at_edge();
    exp_cyc("reset_state", 8'h00, 0, 0, 0, 1);
    rst = 1'b0;

    // Single word, index 0 first
    drive(1'b0, 32'h44332211);
    at_edge(); bus.par_vld = 1'b0;
    exp_cyc("t1_b0", 8'h11, 1, 1, 0, 1);
    exp_cyc("t1_b1", 8'h22, 1, 0, 0, 1);
    exp_cyc("t1_b2", 8'h33, 1, 0, 0, 1);
    exp_cyc("t1_b3", 8'h44, 1, 0, 1, 1);
    exp_cyc("t1_idle", 8'h00, 0, 0, 0, 1);

    // Same word, last index first
    drive(1'b1, 32'h44332211);
    at_edge(); bus.par_vld = 1'b0;
    exp_cyc("t2_b0", 8'h44, 1, 1, 0, 1);
    exp_cyc("t2_b1", 8'h33, 1, 0, 0, 1);
    exp_cyc("t2_b2", 8'h22, 1, 0, 0, 1);
    exp_cyc("t2_b3", 8'h11, 1, 0, 1, 1);
    exp_cyc("t2_idle", 8'h00, 0, 0, 0, 1);

    // Back-to-back: B lands in the hold buffer and streams with no bubble
    drive(1'b0, 32'h04030201);
    at_edge();
    drive(1'b0, 32'h08070605);
    exp_cyc("t3_a0", 8'h01, 1, 1, 0, 1);
    at_edge(); bus.par_vld = 1'b0;
    exp_cyc("t3_a1", 8'h02, 1, 0, 0, 0);
    exp_cyc("t3_a2", 8'h03, 1, 0, 0, 0);
    exp_cyc("t3_a3", 8'h04, 1, 0, 1, 0);
    exp_cyc("t3_b0", 8'h05, 1, 1, 0, 1);
    exp_cyc("t3_b1", 8'h06, 1, 0, 0, 1);
    exp_cyc("t3_b2", 8'h07, 1, 0, 0, 1);
    exp_cyc("t3_b3", 8'h08, 1, 0, 1, 1);
    exp_cyc("t3_idle", 8'h00, 0, 0, 0, 1);

    // Word accepted on the last-beat edge loads straight into the shifter
    drive(1'b0, 32'hA4A3A2A1);
    at_edge(); bus.par_vld = 1'b0;
    exp_cyc("t4_a0", 8'hA1, 1, 1, 0, 1);
    exp_cyc("t4_a1", 8'hA2, 1, 0, 0, 1);
    exp_cyc("t4_a2", 8'hA3, 1, 0, 0, 1);
    exp_cyc("t4_a3", 8'hA4, 1, 0, 1, 1);
    drive(1'b1, 32'hC4C3C2C1);
    at_edge(); bus.par_vld = 1'b0;
    exp_cyc("t4_c0", 8'hC4, 1, 1, 0, 1);
    exp_cyc("t4_c1", 8'hC3, 1, 0, 0, 1);
    exp_cyc("t4_c2", 8'hC2, 1, 0, 0, 1);
    exp_cyc("t4_c3", 8'hC1, 1, 0, 1, 1);
    exp_cyc("t4_idle", 8'h00, 0, 0, 0, 1);

    // Reset mid-word with a held word: both discarded
    drive(1'b0, 32'h14131211);
    at_edge();
    drive(1'b0, 32'h24232221);
    at_edge(); bus.par_vld = 1'b0; rst = 1'b1;
    exp_cyc("t5_beat2", 8'h12, 1, 0, 0, 0);
    at_edge(); rst = 1'b0;
    exp_cyc("t5_after_rst", 8'h00, 0, 0, 0, 1);
    repeat (6) exp_cyc("t5_no_held", 8'h00, 0, 0, 0, 1);

    // No transfer while reset is asserted, even with par_vld high
    rst = 1'b1;
    drive(1'b1, 32'h34333231);
    repeat (2) at_edge();
    bus.par_vld = 1'b0; rst = 1'b0;
    repeat (4) exp_cyc("t6_idle", 8'h00, 0, 0, 0, 1);

    // Random traffic, both beat orders, occasional resets
    frames = 0;
    cyc    = 0;
    while (frames < 1000 && cyc < 30000) begin
      at_edge();
      cyc++;
      rst         = ($urandom_range(0, 499) == 0);
      bus.par_vld = ($urandom_range(0, 3) != 0);
      bus.dir     = dir_e'($urandom_range(0, 1));
      for (int i = 0; i < PW; i++) bus.par[i] = DW'($urandom);
    end
    rst         = 1'b0;
    bus.par_vld = 1'b0;
    check("random_frames_done", 32'(frames >= 1000), 32'd1);
    repeat (12) at_edge();
    @(negedge clk);
    check("drain_no_pending", 32'(sent.size()), 32'd0);
    check("drain_idle", 32'({bus.ser_en, bus.ser}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
